md_unit_pipe: RTL and testbench
===============================

// Module: md_unit_pipe
// PURPOSE
//   Parametrised multi-cycle multiply/divide unit with HI/LO registers, sitting in the E stage
//   beside the ALU of the 5-stage pipeline. Accepts one mult/multu/div/divu/mthi/mtlo per start
//   pulse, holds busy for a configurable latency, then commits HI/LO. The hazard unit stalls
//   D on start|busy when the D-stage instruction uses HI/LO. Successor of the fixed-width ALU
//   path: adds width, latency parameters, cancel and divide-by-zero rules.
// PARAMETERS
//   WIDTH       32  operand/HI/LO width in bits (>=8)
//   MUL_CYCLES  5   cycles busy after a mult/multu start (>=1)
//   DIV_CYCLES  10  cycles busy after a div/divu start (>=1)
// PORTS
//   clk      in   1      rising-edge clock
//   reset    in   1      synchronous, active-low reset
//   start    in   1      one-cycle pulse: launch op with a/b sampled this edge
//   op       in   3      0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 reserved (no-op)
//   a        in   WIDTH  operand rs (dividend / multiplicand / mthi,mtlo data)
//   b        in   WIDTH  operand rt (divisor / multiplier)
//   cancel   in   1      abort in-flight op (E-stage flush / exception)
//   busy     out  1      operation in flight; HI/LO not yet valid
//   hi       out  WIDTH  HI register
//   lo       out  WIDTH  LO register
//   done     out  1      one-cycle pulse on the edge HI/LO were committed by mult/div
// BEHAVIOUR
//   - Reset (reset==0 at clk edge): hi=0, lo=0, busy=0, done=0, counter=0, latched ops cleared;
//     overrides start/cancel; a reset mid-operation discards the result.
//   - FSM: IDLE -> RUN on start with op 0-3 while IDLE; RUN counts down from N-1 to 0
//     (N=MUL_CYCLES or DIV_CYCLES); at count 0 -> IDLE, HI/LO written, done=1 for that cycle.
//   - busy=1 from the cycle after the start edge for exactly N cycles; drops the same edge
//     HI/LO update, so the first non-busy cycle reads the new values.
//   - a, b, op latched at start; later changes on inputs have no effect.
//   - start while busy: ignored (hazard unit guarantees it never happens; bench checks ignore).
//   - mthi/mtlo (op 4/5) while IDLE: write hi/lo at the start edge, busy stays 0, done stays 0.
//     While busy: ignored.
//   - Reserved op 6-7: no state change.
//   - cancel=1: if RUN, return to IDLE, busy=0 next cycle, HI/LO unchanged, no done. cancel
//     together with start in IDLE: start suppressed. cancel with count 0 commit: cancel wins.
//   - mult: signed WIDTH x WIDTH -> 2*WIDTH product, {hi,lo}=product. multu: unsigned.
//   - div: signed; lo=quotient truncated toward zero, hi=remainder with sign of dividend.
//     divu: unsigned.
//   - Divide by zero (b==0): lo = all ones, hi = a (both signed and unsigned); full latency.
//   - Signed overflow (a=MIN, b=-1): lo = MIN, hi = 0; full latency.
//   - Result may be computed combinationally from latched operands; only commit timing is
//     architectural.
// TESTING
//   - reset=0 two cycles then release -> hi=lo=0, busy=0, done=0.
//   - mult a=-3,b=7 (WIDTH=32) -> busy 5 cycles, then hi=32'hFFFFFFFF, lo=32'hFFFFFFEB, done pulse.
//   - divu a=100,b=7 -> busy 10 cycles, lo=14, hi=2; div a=-7,b=2 -> lo=-3, hi=-1.
//   - div a=5,b=0 -> lo=32'hFFFFFFFF, hi=5; div a=32'h80000000,b=-1 -> lo=32'h80000000, hi=0.
//   - mult started, cancel on busy cycle 3 -> busy=0 next cycle, HI/LO keep prior values, no done.
//   - mthi 32'h1234 idle -> hi=32'h1234 next cycle, busy=0; mtlo during busy -> lo unchanged;
//     reset=0 mid-div -> all outputs zero.

Source files
------------

// File: rtl/md_unit_pipe.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Operands are latched at start; the result commits after a fixed latency unless cancelled.
module md_unit_pipe #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done
);

    localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned PROD_W  = 2 * WIDTH;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [PROD_W-1:0]  mul_x, mul_y, prod;
    logic               neg_a, neg_b, is_signed;
    logic [WIDTH-1:0]   num, den, den_safe, uq, ur;
    logic [WIDTH-1:0]   res_hi, res_lo;

    // Result datapath from latched operands; only the commit edge is architectural.
    always_comb begin
        is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
        neg_a     = is_signed & a_q[WIDTH-1];
        neg_b     = is_signed & b_q[WIDTH-1];

        // Sign-extending to 2*WIDTH makes the modular product equal the signed product.
        mul_x = {{WIDTH{neg_a}}, a_q};
        mul_y = {{WIDTH{neg_b}}, b_q};
        prod  = PROD_W'(mul_x * mul_y);

        num      = neg_a ? (~a_q + WIDTH'(1)) : a_q;
        den      = neg_b ? (~b_q + WIDTH'(1)) : b_q;
        den_safe = (den == '0) ? WIDTH'(1) : den;
        uq       = num / den_safe;
        ur       = num % den_safe;

        res_hi = prod[PROD_W-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
            if (b_q == '0) begin
                res_hi = a_q;
                res_lo = '1;
            end else begin
                // MIN / -1 falls out as quotient MIN, remainder 0 from the magnitude path.
                res_lo = (neg_a ^ neg_b) ? (~uq + WIDTH'(1)) : uq;
                res_hi = neg_a ? (~ur + WIDTH'(1)) : ur;
            end
        end
    end

    // Next-state and register updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !cancel) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d = ST_RUN;
                            op_d    = op;
                            a_d     = a;
                            b_d     = b;
                            cnt_d   = ((op == OP_MULT) || (op == OP_MULTU))
                                      ? CNT_W'(MUL_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;

endmodule

// File: tb/tb_md_unit_pipe.sv
// Directed bench for md_unit_pipe (WIDTH=32, 5-cycle multiply, 10-cycle divide).
// Each task drives one scenario and checks against hand-computed values.
module tb_md_unit_pipe;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    md_unit_pipe #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch an op, scramble operands afterwards, then count busy cycles (bounded).
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int cyc, output logic dn);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0; a = $urandom; b = $urandom;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            tick();
        end
        dn = done;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; cancel = 1'b0; op = 3'd0; a = '0; b = '0;
        tick(); tick();
        reset = 1'b1;
        tick();
        n_tests++; if (hi !== 32'h0)  begin n_fail++; $display("FAIL reset_hi got %h exp %h", hi, 32'h0); end
        n_tests++; if (lo !== 32'h0)  begin n_fail++; $display("FAIL reset_lo got %h exp %h", lo, 32'h0); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    endtask

    task automatic test_mult();
        int c; logic d;
        run_op(3'd0, 32'hFFFFFFFD, 32'd7, c, d);
        n_tests++; if (c !== 5)              begin n_fail++; $display("FAIL mult_cycles got %0d exp 5", c); end
        n_tests++; if (d !== 1'b1)           begin n_fail++; $display("FAIL mult_done got %b exp 1", d); end
        n_tests++; if (hi !== 32'hFFFFFFFF)  begin n_fail++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
        n_tests++; if (lo !== 32'hFFFFFFEB)  begin n_fail++; $display("FAIL mult_lo got %h exp ffffffeb", lo); end
        tick();
        n_tests++; if (done !== 1'b0)        begin n_fail++; $display("FAIL mult_done_pulse got %b exp 0", done); end
        run_op(3'd1, 32'hFFFFFFFF, 32'd2, c, d);
        n_tests++; if (hi !== 32'h00000001)  begin n_fail++; $display("FAIL multu_hi got %h exp 00000001", hi); end
        n_tests++; if (lo !== 32'hFFFFFFFE)  begin n_fail++; $display("FAIL multu_lo got %h exp fffffffe", lo); end
    endtask

    task automatic test_div();
        int c; logic d;
        run_op(3'd3, 32'd100, 32'd7, c, d);
        n_tests++; if (c !== 10)             begin n_fail++; $display("FAIL divu_cycles got %0d exp 10", c); end
        n_tests++; if (d !== 1'b1)           begin n_fail++; $display("FAIL divu_done got %b exp 1", d); end
        n_tests++; if (lo !== 32'd14)        begin n_fail++; $display("FAIL divu_lo got %h exp 0000000e", lo); end
        n_tests++; if (hi !== 32'd2)         begin n_fail++; $display("FAIL divu_hi got %h exp 00000002", hi); end
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, c, d);
        n_tests++; if (lo !== 32'hFFFFFFFD)  begin n_fail++; $display("FAIL div_neg_lo got %h exp fffffffd", lo); end
        n_tests++; if (hi !== 32'hFFFFFFFF)  begin n_fail++; $display("FAIL div_neg_hi got %h exp ffffffff", hi); end
        run_op(3'd2, 32'd7, 32'hFFFFFFFE, c, d);
        n_tests++; if (lo !== 32'hFFFFFFFD)  begin n_fail++; $display("FAIL div_negb_lo got %h exp fffffffd", lo); end
        n_tests++; if (hi !== 32'd1)         begin n_fail++; $display("FAIL div_negb_hi got %h exp 00000001", hi); end
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, c, d);
        n_tests++; if (lo !== 32'h7FFFFFFC)  begin n_fail++; $display("FAIL divu_big_lo got %h exp 7ffffffc", lo); end
        n_tests++; if (hi !== 32'd1)         begin n_fail++; $display("FAIL divu_big_hi got %h exp 00000001", hi); end
    endtask

    task automatic test_div_corner();
        int c; logic d;
        run_op(3'd2, 32'd5, 32'd0, c, d);
        n_tests++; if (c !== 10)             begin n_fail++; $display("FAIL divz_cycles got %0d exp 10", c); end
        n_tests++; if (lo !== 32'hFFFFFFFF)  begin n_fail++; $display("FAIL divz_lo got %h exp ffffffff", lo); end
        n_tests++; if (hi !== 32'd5)         begin n_fail++; $display("FAIL divz_hi got %h exp 00000005", hi); end
        run_op(3'd3, 32'h80000000, 32'd0, c, d);
        n_tests++; if (lo !== 32'hFFFFFFFF)  begin n_fail++; $display("FAIL divuz_lo got %h exp ffffffff", lo); end
        n_tests++; if (hi !== 32'h80000000)  begin n_fail++; $display("FAIL divuz_hi got %h exp 80000000", hi); end
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, c, d);
        n_tests++; if (c !== 10)             begin n_fail++; $display("FAIL ovf_cycles got %0d exp 10", c); end
        n_tests++; if (lo !== 32'h80000000)  begin n_fail++; $display("FAIL ovf_lo got %h exp 80000000", lo); end
        n_tests++; if (hi !== 32'h0)         begin n_fail++; $display("FAIL ovf_hi got %h exp 00000000", hi); end
    endtask

    // HI/LO hold 0 / 80000000 from the overflow case when this runs.
    task automatic test_cancel();
        logic saw_done;
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
        tick();
        start = 1'b0;
        tick(); tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        n_tests++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL cancel_busy got %b exp 0", busy); end
        saw_done = done;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
        end
        n_tests++; if (saw_done !== 1'b0)    begin n_fail++; $display("FAIL cancel_done got %b exp 0", saw_done); end
        n_tests++; if (hi !== 32'h0)         begin n_fail++; $display("FAIL cancel_hi got %h exp 00000000", hi); end
        n_tests++; if (lo !== 32'h80000000)  begin n_fail++; $display("FAIL cancel_lo got %h exp 80000000", lo); end
        start = 1'b1; cancel = 1'b1; op = 3'd1; a = 32'd9; b = 32'd9;
        tick();
        start = 1'b0; cancel = 1'b0;
        n_tests++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL cancel_start_busy got %b exp 0", busy); end
    endtask

    task automatic test_mthi_mtlo();
        start = 1'b1; op = 3'd4; a = 32'h1234;
        tick();
        start = 1'b0;
        n_tests++; if (hi !== 32'h1234)      begin n_fail++; $display("FAIL mthi_hi got %h exp 00001234", hi); end
        n_tests++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL mthi_busy got %b exp 0", busy); end
        n_tests++; if (done !== 1'b0)        begin n_fail++; $display("FAIL mthi_done got %b exp 0", done); end
        start = 1'b1; op = 3'd5; a = 32'h5678;
        tick();
        start = 1'b0;
        n_tests++; if (lo !== 32'h5678)      begin n_fail++; $display("FAIL mtlo_lo got %h exp 00005678", lo); end
        start = 1'b1; op = 3'd6; a = 32'hAAAA;
        tick();
        start = 1'b1; op = 3'd7;
        tick();
        start = 1'b0;
        n_tests++; if (hi !== 32'h1234 || lo !== 32'h5678 || busy !== 1'b0)
            begin n_fail++; $display("FAIL reserved_op got hi=%h lo=%h busy=%b exp 00001234 00005678 0", hi, lo, busy); end
    endtask

    task automatic test_busy_ignore();
        int c;
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b1; op = 3'd5; a = 32'hDEAD;
        tick();
        start = 1'b0;
        n_tests++; if (lo !== 32'h5678)      begin n_fail++; $display("FAIL mtlo_busy_lo got %h exp 00005678", lo); end
        start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2;
        tick();
        start = 1'b0;
        c = 3;
        while (busy === 1'b1 && c < 100) begin
            c++;
            tick();
        end
        n_tests++; if (c !== 11)             begin n_fail++; $display("FAIL busy_ignore_cycles got %0d exp 11", c); end
        n_tests++; if (lo !== 32'd14 || hi !== 32'd2)
            begin n_fail++; $display("FAIL busy_ignore_result got hi=%h lo=%h exp 00000002 0000000e", hi, lo); end
    endtask

    task automatic test_back_to_back();
        int c; logic d;
        run_op(3'd0, 32'd6, 32'd7, c, d);
        run_op(3'd1, 32'h00010000, 32'h00010000, c, d);
        n_tests++; if (c !== 5 || d !== 1'b1) begin n_fail++; $display("FAIL b2b_timing got cyc=%0d done=%b exp 5 1", c, d); end
        n_tests++; if (hi !== 32'd1 || lo !== 32'd0)
            begin n_fail++; $display("FAIL b2b_result got hi=%h lo=%h exp 00000001 00000000", hi, lo); end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; op = 3'd2; a = 32'd50; b = 32'd3;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        n_tests++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0 || done !== 1'b0)
            begin n_fail++; $display("FAIL reset_mid got hi=%h lo=%h busy=%b done=%b exp all 0", hi, lo, busy, done); end
        reset = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        n_tests++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL reset_mid_after got hi=%h lo=%h busy=%b exp all 0", hi, lo, busy); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_corner();
        test_cancel();
        test_mthi_mtlo();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
